// File: rtl/riscv_lsu_pkg.sv
// Shared types and constants for the memory-stage load/store unit and its
// peripheral handshake engine.
package riscv_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } periph_state_e;

    // case_sel = {lr valid, sc valid, amo}
    localparam logic [2:0] SEL_NORMAL = 3'b000;
    localparam logic [2:0] SEL_AMO    = 3'b001;
    localparam logic [2:0] SEL_SC     = 3'b010;
    localparam logic [2:0] SEL_LR     = 3'b100;

    // Slice k (bits [64*k +: 64]) belongs to channel k.
    localparam logic [255:0] DEF_PERIPH_BASE = {
        64'h0000_0000_0000_0000,
        64'h0000_0000_0200_BFF8,
        64'h0000_0000_0200_4000,
        64'h0000_0000_1000_0000
    };
    localparam logic [255:0] DEF_PERIPH_MASK = {4{64'hFFFF_FFFF_FFFF_FFF8}};

endpackage

// File: rtl/riscv_lsu_periph_fsm.sv
// Peripheral request engine: valid/ready handshake with timeout, request
// payload registers and captured read data.
module riscv_lsu_periph_fsm
    import riscv_lsu_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int NUM_PERIPH = 4,
    parameter int TIMEOUT    = 16,
    parameter int SEL_W      = 2
) (
    input  logic                       i_riscv_lsu_clk,
    input  logic                       i_riscv_lsu_rst,
    input  logic                       globstall,
    input  logic                       launch,
    input  logic                       launch_we,
    input  logic [SEL_W-1:0]           launch_sel,
    input  logic [XLEN-1:0]            launch_addr,
    input  logic [XLEN-1:0]            launch_wdata,
    input  logic [NUM_PERIPH-1:0]      periph_ready,
    input  logic [NUM_PERIPH*XLEN-1:0] periph_rdata_in,
    output logic [NUM_PERIPH-1:0]      periph_valid,
    output logic                       periph_we,
    output logic [XLEN-1:0]            periph_addr,
    output logic [XLEN-1:0]            periph_wdata,
    output logic [XLEN-1:0]            periph_rdata,
    output logic                       timeout_fault,
    output logic                       busy,
    output periph_state_e              state_dbg
);

    localparam int CW = $clog2(TIMEOUT);

    periph_state_e    state, state_n;
    logic [CW-1:0]    cnt;
    logic [SEL_W-1:0] sel_q;
    logic             sel_ready;
    logic             expired;

    // Valid/ready: valid[k] rises the cycle after launch and stays up until
    // ready[k] is seen, the timeout expires, or reset; other channels' ready
    // is ignored.
    assign sel_ready = periph_ready[sel_q];
    assign expired   = (cnt == CW'(TIMEOUT - 1));
    assign busy      = (state == ST_REQ) || (state == ST_WAIT);
    assign state_dbg = state;

    always_comb begin
        periph_valid = '0;
        for (int k = 0; k < NUM_PERIPH; k++) begin
            periph_valid[k] = busy && (sel_q == SEL_W'(k));
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (launch) state_n = ST_REQ;
            ST_REQ:  state_n = sel_ready ? ST_DONE : ST_WAIT;
            ST_WAIT: if (sel_ready || expired) state_n = ST_DONE;
            ST_DONE: if (!globstall) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_riscv_lsu_clk or posedge i_riscv_lsu_rst) begin
        if (i_riscv_lsu_rst) state <= ST_IDLE;
        else                 state <= state_n;
    end

    always_ff @(posedge i_riscv_lsu_clk or posedge i_riscv_lsu_rst) begin
        if (i_riscv_lsu_rst) begin
            cnt           <= '0;
            sel_q         <= '0;
            periph_we     <= 1'b0;
            periph_addr   <= '0;
            periph_wdata  <= '0;
            periph_rdata  <= '0;
            timeout_fault <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        cnt           <= '0;
                        sel_q         <= launch_sel;
                        periph_we     <= launch_we;
                        periph_addr   <= launch_addr;
                        periph_wdata  <= launch_wdata;
                        timeout_fault <= 1'b0;
                    end
                end
                ST_REQ, ST_WAIT: begin
                    if (sel_ready) begin
                        periph_rdata <= periph_rdata_in[sel_q*XLEN +: XLEN];
                    end else if (state == ST_WAIT && expired) begin
                        periph_rdata  <= '0;
                        timeout_fault <= 1'b1;
                    end else if (cnt != {CW{1'b1}}) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!globstall) timeout_fault <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/riscv_lsu_mmio.sv
// Memory-stage LSU: address decode between dcache and MMIO channels, LR/SC
// reservation tracking, and the stall/fault glue around the peripheral engine.
module riscv_lsu_mmio
    import riscv_lsu_pkg::*;
#(
    parameter int                          XLEN        = 64,
    parameter int                          NUM_PERIPH  = 4,
    parameter logic [NUM_PERIPH*XLEN-1:0]  PERIPH_BASE = DEF_PERIPH_BASE,
    parameter logic [NUM_PERIPH*XLEN-1:0]  PERIPH_MASK = DEF_PERIPH_MASK,
    parameter int                          RSV_G       = 3,
    parameter int                          TIMEOUT     = 16
) (
    input  logic                       i_riscv_lsu_clk,
    input  logic                       i_riscv_lsu_rst,
    input  logic                       i_riscv_lsu_globstall,
    input  logic [XLEN-1:0]            i_riscv_lsu_address,
    input  logic [XLEN-1:0]            i_riscv_lsu_alu_result,
    input  logic [XLEN-1:0]            i_riscv_lsu_wdata,
    input  logic [1:0]                 i_riscv_lsu_lr,
    input  logic [1:0]                 i_riscv_lsu_sc,
    input  logic                       i_riscv_lsu_amo,
    input  logic                       i_riscv_lsu_dcache_wren,
    input  logic                       i_riscv_lsu_dcache_rden,
    input  logic                       i_riscv_lsu_goto_trap,
    input  logic [1:0]                 i_riscv_lsu_return_trap,
    output logic                       o_riscv_lsu_dcache_wren,
    output logic                       o_riscv_lsu_dcache_rden,
    output logic [XLEN-1:0]            o_riscv_lsu_phy_address,
    output logic [XLEN-1:0]            o_riscv_lsu_sc_rdvalue,
    output logic [NUM_PERIPH-1:0]      o_riscv_lsu_periph_valid,
    output logic                       o_riscv_lsu_periph_we,
    output logic [XLEN-1:0]            o_riscv_lsu_periph_addr,
    output logic [XLEN-1:0]            o_riscv_lsu_periph_wdata,
    input  logic [NUM_PERIPH-1:0]      i_riscv_lsu_periph_ready,
    input  logic [NUM_PERIPH*XLEN-1:0] i_riscv_lsu_periph_rdata,
    output logic [XLEN-1:0]            o_riscv_lsu_periph_rdata,
    output logic                       o_riscv_lsu_stall,
    output logic                       o_riscv_lsu_access_fault
);

    localparam int SEL_W = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1;
    localparam int GW    = XLEN - RSV_G;

    logic [2:0]            case_sel;
    logic                  trap;
    logic                  atomic_op;
    logic [NUM_PERIPH-1:0] hit_vec;
    logic                  hit;
    logic [SEL_W-1:0]      hit_sel;
    logic                  sc_success;
    logic                  launch;
    logic                  atomic_fault;
    logic                  busy;
    logic                  timeout_fault;
    periph_state_e         fsm_state;

    logic                  rsv_valid;
    logic [GW-1:0]         rsv_granule;
    logic                  rsv_dw;

    assign case_sel  = {i_riscv_lsu_lr[1], i_riscv_lsu_sc[1], i_riscv_lsu_amo};
    assign trap      = i_riscv_lsu_goto_trap || (|i_riscv_lsu_return_trap);
    assign atomic_op = i_riscv_lsu_lr[1] || i_riscv_lsu_sc[1] || i_riscv_lsu_amo;

    always_comb begin
        hit_vec = '0;
        for (int k = 0; k < NUM_PERIPH; k++) begin
            hit_vec[k] = (i_riscv_lsu_dcache_rden || i_riscv_lsu_dcache_wren) &&
                         ((i_riscv_lsu_alu_result & PERIPH_MASK[k*XLEN +: XLEN])
                          == PERIPH_BASE[k*XLEN +: XLEN]);
        end
    end

    // Descending scan so the lowest matching channel is the one left standing.
    always_comb begin
        hit_sel = '0;
        for (int k = NUM_PERIPH - 1; k >= 0; k--) begin
            if (hit_vec[k]) hit_sel = SEL_W'(k);
        end
    end

    assign hit = |hit_vec;

    assign sc_success = i_riscv_lsu_sc[1] && rsv_valid && !trap &&
                        (i_riscv_lsu_address[XLEN-1:RSV_G] == rsv_granule) &&
                        (rsv_dw == i_riscv_lsu_sc[0]);

    always_comb begin
        o_riscv_lsu_dcache_rden = 1'b0;
        o_riscv_lsu_dcache_wren = 1'b0;
        case (case_sel)
            SEL_NORMAL, SEL_AMO: begin
                o_riscv_lsu_dcache_rden = i_riscv_lsu_dcache_rden;
                o_riscv_lsu_dcache_wren = i_riscv_lsu_dcache_wren;
            end
            SEL_LR: o_riscv_lsu_dcache_rden = 1'b1;
            SEL_SC: o_riscv_lsu_dcache_wren = sc_success;
            default: ;
        endcase
        if (trap || hit) begin
            o_riscv_lsu_dcache_rden = 1'b0;
            o_riscv_lsu_dcache_wren = 1'b0;
        end
    end

    always_comb begin
        o_riscv_lsu_phy_address = atomic_op ? i_riscv_lsu_address : i_riscv_lsu_alu_result;
        if (hit) o_riscv_lsu_phy_address = '0;
    end

    assign o_riscv_lsu_sc_rdvalue = {{(XLEN-1){1'b0}}, i_riscv_lsu_sc[1] && !sc_success};

    // LR sets first; any clearing event the same cycle loses to it.
    always_ff @(posedge i_riscv_lsu_clk or posedge i_riscv_lsu_rst) begin
        if (i_riscv_lsu_rst) begin
            rsv_valid   <= 1'b0;
            rsv_granule <= '0;
            rsv_dw      <= 1'b0;
        end else if (!i_riscv_lsu_globstall) begin
            if (i_riscv_lsu_lr[1]) begin
                rsv_valid   <= 1'b1;
                rsv_granule <= i_riscv_lsu_address[XLEN-1:RSV_G];
                rsv_dw      <= i_riscv_lsu_lr[0];
            end else if (i_riscv_lsu_sc[1] || i_riscv_lsu_goto_trap ||
                         (case_sel == SEL_NORMAL && i_riscv_lsu_dcache_wren &&
                          i_riscv_lsu_alu_result[XLEN-1:RSV_G] == rsv_granule)) begin
                rsv_valid <= 1'b0;
            end
        end
    end

    assign atomic_fault = (fsm_state == ST_IDLE) && hit && !trap && atomic_op;
    assign launch       = (fsm_state == ST_IDLE) && hit && !trap && !atomic_op &&
                          !i_riscv_lsu_globstall;

    assign o_riscv_lsu_stall        = launch || busy;
    assign o_riscv_lsu_access_fault = atomic_fault || timeout_fault;

    riscv_lsu_periph_fsm #(
        .XLEN       (XLEN),
        .NUM_PERIPH (NUM_PERIPH),
        .TIMEOUT    (TIMEOUT),
        .SEL_W      (SEL_W)
    ) u_periph_fsm (
        .i_riscv_lsu_clk (i_riscv_lsu_clk),
        .i_riscv_lsu_rst (i_riscv_lsu_rst),
        .globstall       (i_riscv_lsu_globstall),
        .launch          (launch),
        .launch_we       (i_riscv_lsu_dcache_wren),
        .launch_sel      (hit_sel),
        .launch_addr     (i_riscv_lsu_alu_result),
        .launch_wdata    (i_riscv_lsu_wdata),
        .periph_ready    (i_riscv_lsu_periph_ready),
        .periph_rdata_in (i_riscv_lsu_periph_rdata),
        .periph_valid    (o_riscv_lsu_periph_valid),
        .periph_we       (o_riscv_lsu_periph_we),
        .periph_addr     (o_riscv_lsu_periph_addr),
        .periph_wdata    (o_riscv_lsu_periph_wdata),
        .periph_rdata    (o_riscv_lsu_periph_rdata),
        .timeout_fault   (timeout_fault),
        .busy            (busy),
        .state_dbg       (fsm_state)
    );

endmodule

// File: tb/tb_riscv_lsu_mmio.sv
// Directed bench for riscv_lsu_mmio: LR/SC reservation, MMIO handshake,
// timeout, trap suppression, atomic-to-MMIO fault and mid-access reset.
module tb_riscv_lsu_mmio;

    localparam int XLEN = 64;
    localparam int NP   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            globstall;
    logic [XLEN-1:0] address, alu_result, wdata;
    logic [1:0]      lr, sc, return_trap;
    logic            amo, wren, rden, goto_trap;
    logic            dc_wren, dc_rden;
    logic [XLEN-1:0] phy_address, sc_rdvalue;
    logic [NP-1:0]   p_valid, p_ready;
    logic            p_we;
    logic [XLEN-1:0] p_addr, p_wdata, p_rdata;
    logic [NP*XLEN-1:0] p_rdata_in;
    logic            stall, fault;

    int total = 0;
    int bad   = 0;
    int vcnt, scnt;

    always #5 clk = ~clk;

    riscv_lsu_mmio dut (
        .i_riscv_lsu_clk          (clk),
        .i_riscv_lsu_rst          (rst),
        .i_riscv_lsu_globstall    (globstall),
        .i_riscv_lsu_address      (address),
        .i_riscv_lsu_alu_result   (alu_result),
        .i_riscv_lsu_wdata        (wdata),
        .i_riscv_lsu_lr           (lr),
        .i_riscv_lsu_sc           (sc),
        .i_riscv_lsu_amo          (amo),
        .i_riscv_lsu_dcache_wren  (wren),
        .i_riscv_lsu_dcache_rden  (rden),
        .i_riscv_lsu_goto_trap    (goto_trap),
        .i_riscv_lsu_return_trap  (return_trap),
        .o_riscv_lsu_dcache_wren  (dc_wren),
        .o_riscv_lsu_dcache_rden  (dc_rden),
        .o_riscv_lsu_phy_address  (phy_address),
        .o_riscv_lsu_sc_rdvalue   (sc_rdvalue),
        .o_riscv_lsu_periph_valid (p_valid),
        .o_riscv_lsu_periph_we    (p_we),
        .o_riscv_lsu_periph_addr  (p_addr),
        .o_riscv_lsu_periph_wdata (p_wdata),
        .i_riscv_lsu_periph_ready (p_ready),
        .i_riscv_lsu_periph_rdata (p_rdata_in),
        .o_riscv_lsu_periph_rdata (p_rdata),
        .o_riscv_lsu_stall        (stall),
        .o_riscv_lsu_access_fault (fault)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        address = '0; alu_result = '0; wdata = '0;
        lr = 2'b00; sc = 2'b00; amo = 1'b0; wren = 1'b0; rden = 1'b0;
        goto_trap = 1'b0; return_trap = 2'b00; p_ready = '0;
    endtask

    task automatic sample();
        vcnt += (p_valid != '0) ? 1 : 0;
        scnt += stall ? 1 : 0;
    endtask

    initial begin
        rst = 1'b1; globstall = 1'b0; p_rdata_in = '0;
        idle_inputs();
        #12;
        chk("rst_stall", stall, 0);
        chk("rst_valid", p_valid, 0);
        chk("rst_fault", fault, 0);
        chk("rst_rdata", p_rdata, 0);
        chk("rst_dcache", {dc_wren, dc_rden}, 0);
        @(posedge clk); #1; rst = 1'b0;
        step();

        // LR.D 0x1000 then SC.D 0x1004: same 8-byte granule -> success
        lr = 2'b11; rden = 1'b1; address = 64'h1000; alu_result = 64'h1000; #1;
        chk("lr_rden", dc_rden, 1);
        chk("lr_phy", phy_address, 64'h1000);
        step();
        idle_inputs(); sc = 2'b11; wren = 1'b1; address = 64'h1004; alu_result = 64'h1004; #1;
        chk("sc_ok_val", sc_rdvalue, 0);
        chk("sc_ok_wren", dc_wren, 1);
        step();
        // reservation consumed: second SC fails
        chk("sc_again_val", sc_rdvalue, 1);
        chk("sc_again_wren", dc_wren, 0);
        step();

        // LR.D, SW to same granule, SC.D -> fail
        idle_inputs(); lr = 2'b11; rden = 1'b1; address = 64'h1000; alu_result = 64'h1000;
        step();
        idle_inputs(); wren = 1'b1; alu_result = 64'h1000; #1;
        chk("sw_wren", dc_wren, 1);
        step();
        idle_inputs(); sc = 2'b11; wren = 1'b1; address = 64'h1004; alu_result = 64'h1004; #1;
        chk("sc_clr_val", sc_rdvalue, 1);
        chk("sc_clr_wren", dc_wren, 0);
        step();

        // LR.D then SC.W: width mismatch -> fail
        idle_inputs(); lr = 2'b11; rden = 1'b1; address = 64'h2000; alu_result = 64'h2000;
        step();
        idle_inputs(); sc = 2'b10; wren = 1'b1; address = 64'h2000; alu_result = 64'h2000; #1;
        chk("sc_width_val", sc_rdvalue, 1);
        step();

        // SW to channel 0, ready in second WAIT cycle
        idle_inputs(); wren = 1'b1; alu_result = 64'h1000_0000; wdata = 64'hA5A5_0000_1234;
        vcnt = 0; scnt = 0; #1;
        chk("sw_launch_stall", stall, 1);
        chk("sw_launch_phy", phy_address, 0);
        chk("sw_launch_dcw", dc_wren, 0);
        sample();
        step(); sample();
        chk("sw_req_valid", p_valid, 4'b0001);
        chk("sw_req_we", p_we, 1);
        chk("sw_req_addr", p_addr, 64'h1000_0000);
        chk("sw_req_wdata", p_wdata, 64'hA5A5_0000_1234);
        step(); sample();
        p_ready = 4'b0010;
        step(); sample();
        p_ready = 4'b0001;
        step(); sample();
        idle_inputs();
        chk("sw_done_valid", p_valid, 0);
        chk("sw_done_fault", fault, 0);
        chk("sw_valid_cycles", vcnt, 3);
        chk("sw_stall_cycles", scnt, 4);
        step();

        // LD from channel 2, ready in REQ, DONE held by globstall
        p_rdata_in[64*2 +: 64] = 64'hDEAD;
        p_rdata_in[64*0 +: 64] = 64'h1111;
        p_rdata_in[64*1 +: 64] = 64'hBEEF;
        idle_inputs(); rden = 1'b1; alu_result = 64'h200_BFF8;
        vcnt = 0; scnt = 0; #1; sample();
        step(); sample();
        chk("ld_req_valid", p_valid, 4'b0100);
        p_ready = 4'b0100;
        step(); sample();
        idle_inputs(); globstall = 1'b1;
        chk("ld_done_rdata", p_rdata, 64'hDEAD);
        chk("ld_done_we", p_we, 0);
        chk("ld_stall_cycles", scnt, 2);
        step();
        chk("ld_hold_rdata", p_rdata, 64'hDEAD);
        chk("ld_hold_stall", stall, 0);
        globstall = 1'b0;
        step();

        // read channel 1, never ready -> timeout after 16 valid cycles
        idle_inputs(); rden = 1'b1; alu_result = 64'h200_4000; #1;
        chk("to_launch_stall", stall, 1);
        step();
        idle_inputs();
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (p_valid[1]) vcnt++;
            else break;
            step();
        end
        chk("to_valid_cycles", vcnt, 16);
        chk("to_fault", fault, 1);
        chk("to_rdata", p_rdata, 0);
        chk("to_stall", stall, 0);
        step();

        // trap during hit: no launch, reservation dropped
        idle_inputs(); lr = 2'b11; rden = 1'b1; address = 64'h3000; alu_result = 64'h3000;
        step();
        idle_inputs(); wren = 1'b1; alu_result = 64'h1000_0000; goto_trap = 1'b1; #1;
        chk("trap_stall", stall, 0);
        chk("trap_dcw", dc_wren, 0);
        step();
        chk("trap_valid", p_valid, 0);
        idle_inputs(); sc = 2'b11; wren = 1'b1; address = 64'h3000; alu_result = 64'h3000; #1;
        chk("trap_sc_val", sc_rdvalue, 1);
        step();

        // AMO to an MMIO address faults combinationally without launching
        idle_inputs(); amo = 1'b1; rden = 1'b1; wren = 1'b1;
        address = 64'h1000_0000; alu_result = 64'h1000_0000; #1;
        chk("amo_fault", fault, 1);
        chk("amo_stall", stall, 0);
        step();
        idle_inputs(); #1;
        chk("amo_valid", p_valid, 0);
        chk("amo_fault_clr", fault, 0);

        // reset while in WAIT
        idle_inputs(); wren = 1'b1; alu_result = 64'h1000_0000; wdata = 64'h77;
        step(); step();
        chk("rw_valid_pre", p_valid, 4'b0001);
        idle_inputs();
        rst = 1'b1; #1;
        chk("rw_valid", p_valid, 0);
        chk("rw_stall", stall, 0);
        chk("rw_we_addr", {63'd0, p_we} | p_addr, 0);
        chk("rw_wdata", p_wdata, 0);
        chk("rw_rdata", p_rdata, 0);
        chk("rw_fault", fault, 0);
        step(); rst = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
